// File: rtl/rst_seq_pkg.sv
// ---------------------------------------------------------------------------
// rst_seq_pkg
// Shared definitions for the staged reset-release sequencer.
//   STATE_W  : width of the exported FSM state encoding
//   state_e  : FSM states; the numeric values are visible to software
//              through state_o, so they are fixed here and must not move.
// ---------------------------------------------------------------------------
package rst_seq_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_HOLD      = 2'd0;
    localparam logic [STATE_W-1:0] ST_WAIT_LOCK = 2'd1;
    localparam logic [STATE_W-1:0] ST_RELEASE   = 2'd2;
    localparam logic [STATE_W-1:0] ST_RUN       = 2'd3;

    typedef enum logic [STATE_W-1:0] {
        HOLD      = ST_HOLD,
        WAIT_LOCK = ST_WAIT_LOCK,
        RELEASE   = ST_RELEASE,
        RUN       = ST_RUN
    } state_e;

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Generic single-bit two-flop synchroniser for bringing an asynchronous
// level into the clk domain.
//   clk : destination clock
//   rst : synchronous active-high reset, clears both flops to 0
//   d   : asynchronous input level
//   q   : synchronised level, two clk edges of latency
// ---------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    // Keeps the placer from separating the two flops, maximising the
    // metastability settling time between them.
    (* ASYNC_REG = "TRUE" *) logic [1:0] sync_q;

    // NOTE: flops are written with non-blocking assignments so every
    // register samples its pre-edge inputs; blocking here would collapse
    // the two stages into one.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], d};
        end
    end

    assign q = sync_q[1];

endmodule

// File: rtl/rst_release_seq.sv
// ---------------------------------------------------------------------------
// rst_release_seq
// Staged reset-release sequencer. After power-on reset (or any abort) all
// stage resets are held for MIN_ASSERT cycles, then the block waits for the
// MMCM lock to be stable for LOCK_STABLE cycles and releases the stage
// resets one at a time, STG_GAP cycles apart, bit 0 first. Lock loss in
// RELEASE/RUN or a software request aborts back to HOLD.
//   sys_clk         : single clock for the whole block
//   sys_rst         : synchronous active-high reset
//   mmc_lock        : asynchronous MMCM locked indication
//   soft_rst_req    : one-cycle request to restart the full sequence
//   stg_rst_o       : per-stage active-high resets (registered)
//   all_rdy_o       : 1 while every stage is released (RUN)
//   lock_loss_cnt_o : saturating count of lock losses in RELEASE/RUN
//   state_o         : current FSM state encoding
// ---------------------------------------------------------------------------
module rst_release_seq
    import rst_seq_pkg::*;
#(
    parameter int NUM_STG     = 4,
    parameter int STG_GAP     = 256,
    parameter int LOCK_STABLE = 1024,
    parameter int MIN_ASSERT  = 64,
    parameter int LOSS_CNT_W  = 8
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  mmc_lock,
    input  logic                  soft_rst_req,
    output logic [NUM_STG-1:0]    stg_rst_o,
    output logic                  all_rdy_o,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt_o,
    output logic [STATE_W-1:0]    state_o
);

    // Limits of 1 would give zero-width counters; keep at least one bit.
    localparam int HOLD_W = (MIN_ASSERT  > 1) ? $clog2(MIN_ASSERT)  : 1;
    localparam int STAB_W = (LOCK_STABLE > 1) ? $clog2(LOCK_STABLE) : 1;
    localparam int GAP_W  = (STG_GAP     > 1) ? $clog2(STG_GAP)     : 1;
    localparam int IDX_W  = (NUM_STG     > 1) ? $clog2(NUM_STG)     : 1;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MIN_ASSERT - 1);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STG_GAP - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_STG - 1);

    state_e            state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [STAB_W-1:0] stab_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [IDX_W-1:0]  idx;
    logic              lock_s;
    logic              lock_s_d;
    logic              lock_fall;
    logic              in_active;
    logic              lock_lost;

    sync_2ff u_lock_sync (
        .clk (sys_clk),
        .rst (sys_rst),
        .d   (mmc_lock),
        .q   (lock_s)
    );

    assign lock_fall = lock_s_d & ~lock_s;
    assign in_active = (state == RELEASE) || (state == RUN);
    // Level-based abort: any cycle with lock low while releasing/running.
    assign lock_lost = in_active & ~lock_s;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state           <= HOLD;
            hold_cnt        <= '0;
            stab_cnt        <= '0;
            gap_cnt         <= '0;
            idx             <= '0;
            stg_rst_o       <= '1;
            all_rdy_o       <= 1'b0;
            lock_loss_cnt_o <= '0;
            lock_s_d        <= 1'b0;
        end else begin
            lock_s_d <= lock_s;

            if (lock_fall && in_active && (lock_loss_cnt_o != '1)) begin
                lock_loss_cnt_o <= lock_loss_cnt_o + 1'b1;
            end

            // Lock loss and software request share one abort path, so a
            // coincident pair produces a single HOLD entry.
            if (lock_lost || soft_rst_req) begin
                state     <= HOLD;
                hold_cnt  <= '0;
                stg_rst_o <= '1;
                all_rdy_o <= 1'b0;
            end else begin
                case (state)
                    HOLD: begin
                        if (hold_cnt == HOLD_LAST) begin
                            state    <= WAIT_LOCK;
                            stab_cnt <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                    WAIT_LOCK: begin
                        if (!lock_s) begin
                            stab_cnt <= '0;
                        end else if (stab_cnt == STAB_LAST) begin
                            state   <= RELEASE;
                            gap_cnt <= '0;
                            idx     <= '0;
                        end else begin
                            stab_cnt <= stab_cnt + 1'b1;
                        end
                    end
                    RELEASE: begin
                        if (gap_cnt == GAP_LAST) begin
                            gap_cnt        <= '0;
                            stg_rst_o[idx] <= 1'b0;
                            if (idx == IDX_LAST) begin
                                state     <= RUN;
                                all_rdy_o <= 1'b1;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                    RUN: begin
                        // Stay until an abort.
                    end
                    default: begin
                        state <= HOLD;
                    end
                endcase
            end
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_rst_release_seq.sv
// ---------------------------------------------------------------------------
// tb_rst_release_seq
// Bench for rst_release_seq with NUM_STG=4, STG_GAP=4, LOCK_STABLE=8,
// MIN_ASSERT=16, LOSS_CNT_W=2. A timeline model (phase + elapsed cycles)
// predicts all outputs every cycle; directed scenarios add literal
// expectations, followed by a randomized soak.
// ---------------------------------------------------------------------------
module tb_rst_release_seq;

    localparam int NUM_STG     = 4;
    localparam int STG_GAP     = 4;
    localparam int LOCK_STABLE = 8;
    localparam int MIN_ASSERT  = 16;
    localparam int LOSS_CNT_W  = 2;
    localparam int CNT_MAX     = (1 << LOSS_CNT_W) - 1;

    logic                  sys_clk = 1'b0;
    logic                  sys_rst;
    logic                  mmc_lock;
    logic                  soft_rst_req;
    logic [NUM_STG-1:0]    stg_rst_o;
    logic                  all_rdy_o;
    logic [LOSS_CNT_W-1:0] lock_loss_cnt_o;
    logic [1:0]            state_o;

    int n_cmp = 0;
    int n_bad = 0;

    rst_release_seq #(
        .NUM_STG     (NUM_STG),
        .STG_GAP     (STG_GAP),
        .LOCK_STABLE (LOCK_STABLE),
        .MIN_ASSERT  (MIN_ASSERT),
        .LOSS_CNT_W  (LOSS_CNT_W)
    ) dut (
        .sys_clk         (sys_clk),
        .sys_rst         (sys_rst),
        .mmc_lock        (mmc_lock),
        .soft_rst_req    (soft_rst_req),
        .stg_rst_o       (stg_rst_o),
        .all_rdy_o       (all_rdy_o),
        .lock_loss_cnt_o (lock_loss_cnt_o),
        .state_o         (state_o)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Phase 0..3 = HOLD/WAIT_LOCK/RELEASE/RUN; m_elapsed = cycles spent in
    // the current phase; lock history kept as three sampled values.
    int   m_phase   = 0;
    int   m_elapsed = 0;
    int   m_run     = 0;
    int   m_cnt     = 0;
    logic m_s1 = 1'b0, m_ls = 1'b0, m_lsd = 1'b0;
    logic m_valid = 1'b0;
    logic m_loss;

    function automatic logic [NUM_STG-1:0] exp_stg();
        logic [NUM_STG-1:0] ones = '1;
        if (m_phase == 2) return ones << (m_elapsed / STG_GAP);
        if (m_phase == 3) return '0;
        return ones;
    endfunction

    always @(posedge sys_clk) begin
        if (sys_rst) begin
            m_phase = 0; m_elapsed = 0; m_run = 0; m_cnt = 0;
            m_s1 = 1'b0; m_ls = 1'b0; m_lsd = 1'b0;
            m_valid = 1'b1;
        end else begin
            m_loss = (m_phase >= 2) && !m_ls;
            if (m_loss && m_lsd && m_cnt < CNT_MAX) m_cnt++;
            if (m_loss || soft_rst_req) begin
                m_phase = 0; m_elapsed = 0;
            end else begin
                case (m_phase)
                    0: begin
                        m_elapsed++;
                        if (m_elapsed == MIN_ASSERT) begin m_phase = 1; m_run = 0; end
                    end
                    1: begin
                        if (m_ls) begin
                            m_run++;
                            if (m_run == LOCK_STABLE) begin m_phase = 2; m_elapsed = 0; end
                        end else begin
                            m_run = 0;
                        end
                    end
                    2: begin
                        m_elapsed++;
                        if (m_elapsed == STG_GAP * NUM_STG) m_phase = 3;
                    end
                    default: ;
                endcase
            end
            m_lsd = m_ls; m_ls = m_s1; m_s1 = mmc_lock;
        end
    end

    // Every-cycle comparison, 1 time unit after the active edge.
    always @(posedge sys_clk) begin
        #1;
        if (m_valid) begin
            check("m_state", 32'(state_o), 32'(m_phase));
            check("m_stg_rst", 32'(stg_rst_o), 32'(exp_stg()));
            check("m_all_rdy", 32'(all_rdy_o), 32'(m_phase == 3));
            check("m_loss_cnt", 32'(lock_loss_cnt_o), 32'(m_cnt));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic wait_run(input string name);
        int k = 0;
        while (m_phase != 3 && k < 300) begin step(1); k++; end
        check(name, 32'(state_o), 32'd3);
    endtask

    task automatic lock_drop_in_run(input logic with_soft);
        mmc_lock = 1'b0;
        step(2);
        check("drop_not_yet", 32'(stg_rst_o), 32'h0);
        soft_rst_req = with_soft;
        step(1);
        soft_rst_req = 1'b0;
        check("drop_stg", 32'(stg_rst_o), 32'hF);
        check("drop_rdy", 32'(all_rdy_o), 32'd0);
        check("drop_state", 32'(state_o), 32'd0);
    endtask

    initial begin
        sys_rst      = 1'b1;
        mmc_lock     = 1'b1;
        soft_rst_req = 1'b0;
        step(3);
        check("rst_stg", 32'(stg_rst_o), 32'hF);
        check("rst_rdy", 32'(all_rdy_o), 32'd0);
        check("rst_cnt", 32'(lock_loss_cnt_o), 32'd0);
        check("rst_state", 32'(state_o), 32'd0);

        // Power-up: HOLD 16, WAIT_LOCK 8, four stage steps 4 apart.
        sys_rst = 1'b0;
        step(15); check("pu_hold15", 32'(state_o), 32'd0);
        step(1);  check("pu_wait", 32'(state_o), 32'd1);
        step(8);  check("pu_release", 32'(state_o), 32'd2);
                  check("pu_stg_24", 32'(stg_rst_o), 32'hF);
        step(3);  check("pu_stg_27", 32'(stg_rst_o), 32'hF);
        step(1);  check("pu_stg_28", 32'(stg_rst_o), 32'hE);
        step(4);  check("pu_stg_32", 32'(stg_rst_o), 32'hC);
        step(4);  check("pu_stg_36", 32'(stg_rst_o), 32'h8);
        step(3);  check("pu_rdy_39", 32'(all_rdy_o), 32'd0);
        step(1);  check("pu_stg_40", 32'(stg_rst_o), 32'h0);
                  check("pu_rdy_40", 32'(all_rdy_o), 32'd1);
                  check("pu_state_40", 32'(state_o), 32'd3);

        // Lock drop in RUN, then replay on relock.
        lock_drop_in_run(1'b0);
        check("drop1_cnt", 32'(lock_loss_cnt_o), 32'd1);
        mmc_lock = 1'b1;
        wait_run("relock_run");
        check("relock_cnt", 32'(lock_loss_cnt_o), 32'd1);

        // Soft request from RUN, then again mid-RELEASE after stage 1.
        soft_rst_req = 1'b1; step(1); soft_rst_req = 1'b0;
        check("soft_run_stg", 32'(stg_rst_o), 32'hF);
        begin
            int k = 0;
            while (!(m_phase == 2 && m_elapsed >= 8) && k < 200) begin step(1); k++; end
        end
        check("mid_rel_stg", 32'(stg_rst_o), 32'hC);
        soft_rst_req = 1'b1; step(1); soft_rst_req = 1'b0;
        check("soft_rel_stg", 32'(stg_rst_o), 32'hF);
        check("soft_rel_state", 32'(state_o), 32'd0);
        check("soft_rel_cnt", 32'(lock_loss_cnt_o), 32'd1);
        step(15); check("soft_hold15", 32'(state_o), 32'd0);
        step(1);  check("soft_wait", 32'(state_o), 32'd1);

        // One-cycle lock glitch seen when stab_cnt=5: full recount.
        step(3); mmc_lock = 1'b0;
        step(1); mmc_lock = 1'b1;
        step(9); check("glitch_still_wait", 32'(state_o), 32'd1);
        step(1); check("glitch_release", 32'(state_o), 32'd2);
                 check("glitch_cnt", 32'(lock_loss_cnt_o), 32'd1);
        wait_run("glitch_run");

        // Lock drop and soft request on the same edge: one count.
        lock_drop_in_run(1'b1);
        check("both_cnt", 32'(lock_loss_cnt_o), 32'd2);
        step(1); check("both_hold", 32'(state_o), 32'd0);
        mmc_lock = 1'b1;
        wait_run("both_run");

        // Saturation of the 2-bit loss counter.
        for (int i = 0; i < 5; i++) begin
            lock_drop_in_run(1'b0);
            check("sat_cnt", 32'(lock_loss_cnt_o), 32'((3 + i > CNT_MAX) ? CNT_MAX : 3 + i));
            mmc_lock = 1'b1;
            wait_run("sat_run");
        end

        // sys_rst clears everything including the loss counter.
        sys_rst = 1'b1; step(1);
        check("srst_cnt", 32'(lock_loss_cnt_o), 32'd0);
        check("srst_stg", 32'(stg_rst_o), 32'hF);
        check("srst_rdy", 32'(all_rdy_o), 32'd0);
        check("srst_state", 32'(state_o), 32'd0);
        sys_rst = 1'b0;

        // Randomized soak against the model.
        for (int i = 0; i < 4000; i++) begin
            soft_rst_req = ($urandom_range(0, 63) == 0);
            sys_rst      = ($urandom_range(0, 999) == 0);
            if (mmc_lock) mmc_lock = ($urandom_range(0, 99) != 0);
            else          mmc_lock = ($urandom_range(0, 2) == 0);
            step(1);
        end
        soft_rst_req = 1'b0;
        sys_rst      = 1'b0;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
